// File: rtl/register_5bit_serial_tx_pkg.sv
// Shared types and sizing helpers for the 5-bit serial transmitter.
// Holds the FSM state enum, the frame-length function and counter-width helpers.
package register_5bit_serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  localparam int DEF_WIDTH      = 5;
  localparam int DEF_BIT_CYCLES = 4;
  localparam int DEF_PARITY     = 1;

  // Frame length in bits: start + data + optional parity + stop.
  function automatic int frame_bits(input int width, input int parity);
    return 2 + width + parity;
  endfunction

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_BIT_CYCLES);

endpackage

// File: rtl/register_5bit_serial_tx_if.sv
// Load/Ready handshake plus serial line and status for the transmitter.
// master = word producer side, slave = transmitter side.
interface register_5bit_serial_tx_if #(
  parameter int WIDTH = 5
);
  logic             Load;
  logic [WIDTH-1:0] inData;
  logic             SerialOut;
  logic             Ready;
  logic             Busy;
  logic             Done;

  modport master (
    output Load,
    output inData,
    input  SerialOut,
    input  Ready,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Load,
    input  inData,
    output SerialOut,
    output Ready,
    output Busy,
    output Done
  );
endinterface

// File: rtl/register_5bit_serial_tx_bit_timer.sv
// Bit-period divider: counts 0..BIT_CYCLES-1, tick_o high on the last cycle of each period.
// restart_i synchronously holds the count at zero so a new frame starts on a clean period.
module register_5bit_serial_tx_bit_timer
  import register_5bit_serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic Clock,
  input  logic Clear_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int             CW   = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/register_5bit_serial_tx.sv
// Parallel-in serial-out transmitter: start bit, data LSB first, optional even parity, stop bit.
// Every output is registered; the bit timer paces state changes, the FSM owns shift/parity state.
module register_5bit_serial_tx
  import register_5bit_serial_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int PARITY     = DEF_PARITY
) (
  input  logic                      Clock,
  input  logic                      Clear_n,
  register_5bit_serial_tx_if.slave  bus
);

  localparam int            BIT_W    = cnt_width(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  tx_state_e        state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [BIT_W-1:0] bit_q;
  logic             par_q;
  logic             ser_q;
  logic             rdy_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;

  // Timer is parked at zero while idle so START always gets a full bit period.
  register_5bit_serial_tx_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .Clock     (Clock),
    .Clear_n   (Clear_n),
    .restart_i (state_q == IDLE),
    .tick_o    (tick)
  );

  assign shift_d = shift_q >> 1;

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ser_q  <= 1'b1;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          if (bus.Load) begin
            shift_q <= bus.inData;
            par_q   <= ^bus.inData;
            bit_q   <= '0;
            state_q <= START;
            ser_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            ser_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_d;
            if (bit_q == LAST_BIT) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= PAR;
                ser_q   <= par_q;
              end else begin
                state_q <= STOP;
                ser_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              ser_q <= shift_d[0];
            end
          end
        end
        PAR: begin
          if (tick) begin
            state_q <= STOP;
            ser_q   <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            ser_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b1;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SerialOut = ser_q;
  assign bus.Ready     = rdy_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_register_5bit_serial_tx.sv
// Directed bench for register_5bit_serial_tx: default config plus a BIT_CYCLES=1, no-parity instance.
module tb_register_5bit_serial_tx;

  logic Clock = 1'b0;
  logic Clear_n;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   last_done = -1;
  int   done_gap  = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  register_5bit_serial_tx_if #(.WIDTH(5)) bus  ();
  register_5bit_serial_tx_if #(.WIDTH(5)) bus2 ();

  register_5bit_serial_tx #(.WIDTH(5), .BIT_CYCLES(4), .PARITY(1)) dut (
    .Clock   (Clock),
    .Clear_n (Clear_n),
    .bus     (bus)
  );

  register_5bit_serial_tx #(.WIDTH(5), .BIT_CYCLES(1), .PARITY(0)) dut_min (
    .Clock   (Clock),
    .Clear_n (Clear_n),
    .bus     (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic start_frame(input logic [4:0] d);
    chk("ready_before_load", {31'd0, bus.Ready}, 32'd1);
    bus.Load   = 1'b1;
    bus.inData = d;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // seq[k] is frame bit k; walks all 32 cycles, returns at the negedge of the Done cycle.
  task automatic check_frame(input string name, input logic [7:0] seq, input bit hold,
                             input logic [4:0] next_d, input int inject_at);
    for (int c = 0; c < 32; c++) begin
      if (c == 0 && !hold) bus.Load = 1'b0;
      if (c == 1 && hold)  bus.inData = next_d;
      if (c == inject_at) begin
        bus.Load   = 1'b1;
        bus.inData = 5'd5;
      end
      if (inject_at >= 0 && c == inject_at + 1) bus.Load = 1'b0;
      chk($sformatf("%s_ser_c%0d", name, c), {31'd0, bus.SerialOut}, {31'd0, seq[c/4]});
      chk($sformatf("%s_busy_c%0d", name, c), {31'd0, bus.Busy}, 32'd1);
      chk($sformatf("%s_rdy_c%0d", name, c), {31'd0, bus.Ready}, 32'd0);
      chk($sformatf("%s_done_c%0d", name, c), {31'd0, bus.Done}, 32'd0);
      @(negedge Clock);
    end
    chk({name, "_done_end"}, {31'd0, bus.Done}, 32'd1);
    chk({name, "_rdy_end"}, {31'd0, bus.Ready}, 32'd1);
    chk({name, "_busy_end"}, {31'd0, bus.Busy}, 32'd0);
    chk({name, "_ser_end"}, {31'd0, bus.SerialOut}, 32'd1);
    if (last_done >= 0) done_gap = cyc - last_done;
    last_done = cyc;
  endtask

  logic [6:0] seq_min;

  initial begin
    Clear_n     = 1'b1;
    bus.Load    = 1'b0;
    bus.inData  = 5'd0;
    bus2.Load   = 1'b0;
    bus2.inData = 5'd0;
    #2 Clear_n = 1'b0;
    #1;
    chk("rst_ser", {31'd0, bus.SerialOut}, 32'd1);
    chk("rst_rdy", {31'd0, bus.Ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_min_ser", {31'd0, bus2.SerialOut}, 32'd1);
    chk("rst_min_rdy", {31'd0, bus2.Ready}, 32'd1);
    @(negedge Clock);
    @(negedge Clock);
    Clear_n = 1'b1;
    @(negedge Clock);

    // Basic frame 10110 -> 0,0,1,1,0,1,1,1
    start_frame(5'b10110);
    check_frame("basic", 8'b11101100, 1'b0, 5'd0, -1);
    @(negedge Clock);
    chk("basic_done_one_cycle", {31'd0, bus.Done}, 32'd0);

    // Zero word: parity 0
    start_frame(5'd0);
    check_frame("zero", 8'b10000000, 1'b0, 5'd0, -1);
    @(negedge Clock);

    // Load of 5 during a frame of 31 must be ignored
    start_frame(5'd31);
    check_frame("ignored", 8'b11111110, 1'b0, 5'd0, 10);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      chk($sformatf("ignored_no_2nd_done_%0d", i), {31'd0, bus.Done}, 32'd0);
    end

    // Reset during data bit 2 of a zero word
    start_frame(5'd0);
    bus.Load = 1'b0;
    repeat (13) @(negedge Clock);
    chk("midrst_ser_before", {31'd0, bus.SerialOut}, 32'd0);
    chk("midrst_busy_before", {31'd0, bus.Busy}, 32'd1);
    Clear_n = 1'b0;
    #1;
    chk("midrst_ser", {31'd0, bus.SerialOut}, 32'd1);
    chk("midrst_rdy", {31'd0, bus.Ready}, 32'd1);
    chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.Done}, 32'd0);
    @(negedge Clock);
    Clear_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      chk($sformatf("midrst_no_done_%0d", i), {31'd0, bus.Done}, 32'd0);
    end
    start_frame(5'd10);
    check_frame("after_rst", 8'b10010100, 1'b0, 5'd0, -1);
    @(negedge Clock);

    // Back-to-back with Load held high: 1 then 2
    last_done = -1;
    start_frame(5'd1);
    check_frame("b2b_first", 8'b11000010, 1'b1, 5'd2, -1);
    @(posedge Clock);
    @(negedge Clock);
    check_frame("b2b_second", 8'b11000100, 1'b0, 5'd0, -1);
    chk("b2b_done_gap", done_gap, 32'd33);
    @(negedge Clock);

    // Minimal config: 00011, one cycle per bit, no parity -> 0,1,1,0,0,0,1
    seq_min = 7'b1000110;
    chk("min_ready", {31'd0, bus2.Ready}, 32'd1);
    bus2.Load   = 1'b1;
    bus2.inData = 5'b00011;
    @(posedge Clock);
    @(negedge Clock);
    bus2.Load = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("min_ser_c%0d", c), {31'd0, bus2.SerialOut}, {31'd0, seq_min[c]});
      chk($sformatf("min_busy_c%0d", c), {31'd0, bus2.Busy}, 32'd1);
      chk($sformatf("min_done_c%0d", c), {31'd0, bus2.Done}, 32'd0);
      @(negedge Clock);
    end
    chk("min_done_end", {31'd0, bus2.Done}, 32'd1);
    chk("min_busy_end", {31'd0, bus2.Busy}, 32'd0);
    chk("min_rdy_end", {31'd0, bus2.Ready}, 32'd1);
    chk("min_ser_end", {31'd0, bus2.SerialOut}, 32'd1);
    @(negedge Clock);
    chk("min_done_one_cycle", {31'd0, bus2.Done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
